// File: rtl/tagged_demultiplexer_if.sv
// Stream interfaces for the tagged demultiplexer: tagged input (tagged_i)
// and per-destination data output (data_i).
interface tagged_i #(
    parameter type data_t    = logic [63:0],
    parameter int  TAG_WIDTH = 2
);
    data_t                data;
    logic [TAG_WIDTH-1:0] tag;
    logic                 keep;
    logic                 last;
    logic                 valid;
    logic                 ready;

    modport m (output data, tag, keep, last, valid, input ready);
    modport s (input data, tag, keep, last, valid, output ready);
endinterface

interface data_i #(
    parameter type data_t = logic [63:0]
);
    data_t data;
    logic  keep;
    logic  last;
    logic  valid;
    logic  ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_demultiplexer.sv
// Steers a tagged stream to per-tag output registers, with optional last broadcast.
// Optional drop counter port enabled by defining TAGGED_DEMUX_STATS_EN.
//
// state    | meaning
// ST_RUN   | normal routing, s0 element may move to its output
// ST_FLUSH | dummy lasts still owed to busy outputs, input held off
module tagged_demultiplexer #(
    parameter type data_t        = logic [63:0],
    parameter int  NUM_OUTPUTS   = 4,
    parameter int  TAG_WIDTH     = 2,
    parameter int  LAST_HANDLING = 1,
    parameter int  FILTER_KEEP   = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    tagged_i.s    in,
    data_i.m      out [NUM_OUTPUTS]
`ifdef TAGGED_DEMUX_STATS_EN
    ,
    output logic [31:0] drop_count
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic                   rst_int_n;
    logic [1:0]             rst_sync_q;

    state_t                 state_q, state_d;
    logic [NUM_OUTPUTS-1:0] pending_q, pending_d;
    data_t                  flush_data_q, flush_data_d;

    logic                   s0_valid_q, s0_valid_d;
    data_t                  s0_data_q, s0_data_d;
    logic [TAG_WIDTH-1:0]   s0_tag_q, s0_tag_d;
    logic                   s0_keep_q, s0_keep_d;
    logic                   s0_last_q, s0_last_d;

    logic [NUM_OUTPUTS-1:0] o_valid_q, o_valid_d;
    logic [NUM_OUTPUTS-1:0] o_keep_q, o_keep_d;
    logic [NUM_OUTPUTS-1:0] o_last_q, o_last_d;
    data_t                  o_data_q [NUM_OUTPUTS];
    data_t                  o_data_d [NUM_OUTPUTS];

    logic [NUM_OUTPUTS-1:0] o_ready;
    logic [NUM_OUTPUTS-1:0] o_free;
    logic [NUM_OUTPUTS-1:0] sel;
    logic                   tag_ok;
    logic                   keep_drop;
    logic                   drop;
    logic                   bcast_en;
    logic                   dest_free;
    logic                   s0_moves;
    logic                   in_ready;
    logic                   in_hs;

    // Assert asynchronously, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (s0_tag_q == TAG_WIDTH'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

    assign o_free    = ~o_valid_q | o_ready;
    assign tag_ok    = |sel;
    assign keep_drop = (FILTER_KEEP != 0) && !s0_keep_q && !s0_last_q;
    assign drop      = !tag_ok || keep_drop;
    assign bcast_en  = (LAST_HANDLING == 0) && s0_last_q;
    assign dest_free = |(sel & o_free);
    assign s0_moves  = s0_valid_q && (state_q == ST_RUN) && (drop || dest_free);
    assign in_ready  = rst_int_n && (state_q == ST_RUN) && (!s0_valid_q || s0_moves);
    assign in_hs     = in.valid && in_ready;
    assign in.ready  = in_ready;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_data_d  = s0_data_q;
        s0_tag_d   = s0_tag_q;
        s0_keep_d  = s0_keep_q;
        s0_last_d  = s0_last_q;
        if (s0_moves) begin
            s0_valid_d = 1'b0;
        end
        if (in_hs) begin
            s0_valid_d = 1'b1;
            s0_data_d  = in.data;
            s0_tag_d   = in.tag;
            s0_keep_d  = in.keep;
            s0_last_d  = in.last;
        end
    end

    // Per-output register: drain when free, reload in the same cycle if there is work.
    always_comb begin
        o_valid_d = o_valid_q;
        o_keep_d  = o_keep_q;
        o_last_d  = o_last_q;
        o_data_d  = o_data_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (o_free[i]) begin
                o_valid_d[i] = 1'b0;
            end
            if (state_q == ST_FLUSH) begin
                if (pending_q[i] && o_free[i]) begin
                    o_valid_d[i] = 1'b1;
                    o_data_d[i]  = flush_data_q;
                    o_keep_d[i]  = 1'b0;
                    o_last_d[i]  = 1'b1;
                    pending_d[i] = 1'b0;
                end
            end else if (s0_moves) begin
                if (sel[i] && !drop) begin
                    o_valid_d[i] = 1'b1;
                    o_data_d[i]  = s0_data_q;
                    o_keep_d[i]  = s0_keep_q;
                    o_last_d[i]  = s0_last_q;
                end else if (bcast_en) begin
                    if (o_free[i]) begin
                        o_valid_d[i] = 1'b1;
                        o_data_d[i]  = s0_data_q;
                        o_keep_d[i]  = 1'b0;
                        o_last_d[i]  = 1'b1;
                    end else begin
                        pending_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_data_d = flush_data_q;
        case (state_q)
            ST_RUN: begin
                if (s0_moves && bcast_en) begin
                    flush_data_d = s0_data_q;
                    if (|pending_d) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pending_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= ST_RUN;
            pending_q    <= '0;
            flush_data_q <= '0;
            s0_valid_q   <= 1'b0;
            s0_data_q    <= '0;
            s0_tag_q     <= '0;
            s0_keep_q    <= 1'b0;
            s0_last_q    <= 1'b0;
            o_valid_q    <= '0;
            o_keep_q     <= '0;
            o_last_q     <= '0;
            o_data_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            flush_data_q <= flush_data_d;
            s0_valid_q   <= s0_valid_d;
            s0_data_q    <= s0_data_d;
            s0_tag_q     <= s0_tag_d;
            s0_keep_q    <= s0_keep_d;
            s0_last_q    <= s0_last_d;
            o_valid_q    <= o_valid_d;
            o_keep_q     <= o_keep_d;
            o_last_q     <= o_last_d;
            o_data_q     <= o_data_d;
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
        assign out[g].valid = o_valid_q[g];
        assign out[g].data  = o_data_q[g];
        assign out[g].keep  = o_keep_q[g];
        assign out[g].last  = o_last_q[g];
        assign o_ready[g]   = out[g].ready;
    end

`ifdef TAGGED_DEMUX_STATS_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Saturating: invalid tags and keep-filtered elements both count.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (s0_moves && drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    // Without the counter, dropped elements leave no trace.
`endif

endmodule

// File: tb/tb_tagged_demultiplexer.sv
// Scoreboard bench: dut_a broadcasts last over 4 outputs, dut_b forwards last over 3 outputs.
module tb_tagged_demultiplexer;

    typedef logic [65:0] ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tagged_i a_in ();
    data_i   a_out [4] ();
    tagged_i b_in ();
    data_i   b_out [3] ();

    logic [3:0] a_rdy, a_vld;
    ent_t       a_ent [4];
    logic [2:0] b_rdy, b_vld;
    ent_t       b_ent [3];

`ifdef TAGGED_DEMUX_STATS_EN
    logic [31:0] a_drop, b_drop;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_a
        assign a_out[g].ready = a_rdy[g];
        assign a_vld[g]       = a_out[g].valid;
        assign a_ent[g]       = {a_out[g].data, a_out[g].keep, a_out[g].last};
    end

    for (genvar g = 0; g < 3; g++) begin : g_b
        assign b_out[g].ready = b_rdy[g];
        assign b_vld[g]       = b_out[g].valid;
        assign b_ent[g]       = {b_out[g].data, b_out[g].keep, b_out[g].last};
    end

    tagged_demultiplexer #(
        .NUM_OUTPUTS(4), .TAG_WIDTH(2), .LAST_HANDLING(0), .FILTER_KEEP(1)
    ) dut_a (
        .clk(clk),
        .rst_n(rst_n),
        .in(a_in),
        .out(a_out)
`ifdef TAGGED_DEMUX_STATS_EN
        ,
        .drop_count(a_drop)
`endif
    );

    tagged_demultiplexer #(
        .NUM_OUTPUTS(3), .TAG_WIDTH(2), .LAST_HANDLING(1), .FILTER_KEEP(1)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_n),
        .in(b_in),
        .out(b_out)
`ifdef TAGGED_DEMUX_STATS_EN
        ,
        .drop_count(b_drop)
`endif
    );

    ent_t aq [4][$];
    ent_t bq [3][$];
    int   a_hs_cyc [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Called at a negedge; pushes expectations, waits for the handshake, returns at a negedge.
    task automatic send(input bit to_b, input int tag, input logic [63:0] data,
                        input bit keep, input bit last, output int hs_cyc);
        int n = 0;
        int nout;
        bit dropped;
        nout    = to_b ? 3 : 4;
        dropped = (tag >= nout) || (!keep && !last);
        if (!dropped) begin
            if (to_b) bq[tag].push_back({data, keep, last});
            else      aq[tag].push_back({data, keep, last});
        end
        if (!to_b && last) begin
            for (int i = 0; i < 4; i++) begin
                if (dropped || i != tag) aq[i].push_back({data, 1'b0, 1'b1});
            end
        end
        if (to_b) begin
            b_in.valid = 1'b1; b_in.tag = tag[1:0]; b_in.data = data;
            b_in.keep = keep; b_in.last = last;
        end else begin
            a_in.valid = 1'b1; a_in.tag = tag[1:0]; a_in.data = data;
            a_in.keep = keep; a_in.last = last;
        end
        #1;
        while (!(to_b ? b_in.ready : a_in.ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        if (to_b) b_in.valid = 1'b0;
        else      a_in.valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a_vld[i] && a_rdy[i]) begin
                a_hs_cyc[i] = cyc;
                if (aq[i].size() == 0) chk($sformatf("a_out%0d_extra", i), aq[i].size(), 1);
                else                   chk($sformatf("a_out%0d", i), a_ent[i], aq[i].pop_front());
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (b_vld[i] && b_rdy[i]) begin
                if (bq[i].size() == 0) chk($sformatf("b_out%0d_extra", i), bq[i].size(), 1);
                else                   chk($sformatf("b_out%0d", i), b_ent[i], bq[i].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        int hsc [4];
        int n;
`ifdef TAGGED_DEMUX_STATS_EN
        logic [31:0] d0;
`endif
        rst_n = 1'b0;
        a_rdy = '1;
        b_rdy = '1;
        a_in.valid = 1'b0; a_in.tag = '0; a_in.data = '0; a_in.keep = 1'b0; a_in.last = 1'b0;
        b_in.valid = 1'b0; b_in.tag = '0; b_in.data = '0; b_in.keep = 1'b0; b_in.last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_valid", a_vld, 0);
        chk("rst_a_ready", a_in.ready, 0);
        chk("rst_b_valid", b_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", a_in.ready, 1);

        // Routing across all outputs, latency 2
        for (int t = 0; t < 4; t++) begin
            send(1'b0, t, 64'hA0 + 64'(t), 1'b1, 1'b0, hs);
            hsc[t] = hs;
        end
        repeat (4) @(negedge clk);
        for (int t = 0; t < 4; t++) chk($sformatf("route_lat%0d", t), a_hs_cyc[t] - hsc[t], 2);

        // Head-of-line blocking behind a stalled out[2]
        a_rdy[2] = 1'b0;
        fork
            begin
                send(1'b0, 2, 64'hB0, 1'b1, 1'b0, hs);
                send(1'b0, 2, 64'hB2, 1'b1, 1'b0, hs);
                send(1'b0, 1, 64'hB1, 1'b1, 1'b0, hs);
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    chk("bp_in_ready", a_in.ready, 0);
                    chk("bp_out2_valid", a_vld[2], 1);
                    chk("bp_out2_data", a_ent[2], {64'hB0, 2'b10});
                    chk("bp_out1_idle", a_vld[1], 0);
                    @(negedge clk);
                end
                a_rdy[2] = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Broadcast last with out[3] full and stalled
        a_rdy[3] = 1'b0;
        send(1'b0, 3, 64'hD3, 1'b1, 1'b0, hs);
        send(1'b0, 1, 64'hD1, 1'b1, 1'b1, hs);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("bc_in_ready_low", a_in.ready, 0);
            chk("bc_out3_held", a_ent[3], {64'hD3, 2'b10});
            @(negedge clk);
        end
        a_rdy[3] = 1'b1;
        #1;
        n = 0;
        while (!a_in.ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bc_in_ready_back", a_in.ready, 1);
        @(negedge clk);
        repeat (3) @(negedge clk);

        // Keep filter: first dropped, second forwarded as keep=0 last=1
`ifdef TAGGED_DEMUX_STATS_EN
        d0 = a_drop;
`endif
        send(1'b0, 0, 64'hE0, 1'b0, 1'b0, hs);
        send(1'b0, 0, 64'hE1, 1'b0, 1'b1, hs);
        repeat (4) @(negedge clk);
`ifdef TAGGED_DEMUX_STATS_EN
        chk("a_drop_keep", a_drop, d0 + 32'd1);
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("filter_drained%0d", i), aq[i].size(), 0);

        // Invalid tag and forward-only last on the 3-output instance
`ifdef TAGGED_DEMUX_STATS_EN
        chk("b_drop_init", b_drop, 0);
`endif
        send(1'b1, 3, 64'hCC, 1'b1, 1'b0, hs);
        for (int k = 0; k < 5; k++) begin
            chk("inv_no_valid", b_vld, 0);
            @(negedge clk);
        end
`ifdef TAGGED_DEMUX_STATS_EN
        chk("b_drop_inv", b_drop, 1);
`endif
        send(1'b1, 2, 64'hF2, 1'b1, 1'b1, hs);
        send(1'b1, 0, 64'hF0, 1'b1, 1'b0, hs);
        send(1'b1, 1, 64'hF1, 1'b1, 1'b0, hs);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("b_drained%0d", i), bq[i].size(), 0);

        // Reset while in FLUSH with out[0] holding data
        a_rdy = 4'b0110;
        send(1'b0, 0, 64'h10, 1'b1, 1'b0, hs);
        send(1'b0, 3, 64'h13, 1'b1, 1'b0, hs);
        send(1'b0, 1, 64'h11, 1'b1, 1'b1, hs);
        repeat (2) @(negedge clk);
        chk("rst_pre_flush", dut_a.state_q, 1);
        chk("rst_pre_out0", a_vld[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", a_vld, 0);
        chk("rst_async_ready", a_in.ready, 0);
        for (int i = 0; i < 4; i++) aq[i].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_post_state", dut_a.state_q, 0);
        chk("rst_post_pending", dut_a.pending_q, 0);
        chk("rst_post_ready", a_in.ready, 1);
        a_rdy = '1;
        send(1'b0, 2, 64'h22, 1'b1, 1'b0, hs);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) chk($sformatf("a_final_empty%0d", i), aq[i].size(), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("b_final_empty%0d", i), bq[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
